mmio_io_hub: RTL and testbench
==============================

// Module: mmio_io_hub
// PURPOSE
//  Parametrised memory-mapped I/O hub for the minisys single-cycle CPU. It replaces the separate
//  ioread/leds logic with one block: a debounced switch input register, LED_BANKS LED output
//  registers, a sticky confirm-button status, and an optional blocking-read handshake that stalls the
//  CPU until confirm is pressed. It sits between the Controller/ALU address path and the board pins.
// PARAMETERS
//  DATA_W        32        CPU data/address width
//  SW_W          16        switch input width (<= DATA_W)
//  LED_W         16        width of one LED bank (<= DATA_W)
//  LED_BANKS     2         number of LED banks; led_out = {bank[N-1],...,bank[0]}
//  DEBOUNCE_CYC  20000     cycles an input must stay stable before the debounced value changes (>=2)
//  READ_BLOCKING 1         1: switch read stalls until confirm press; 0: switch read is immediate
// PORTS
//  clock       in   1                  system clock, rising edge
//  reset       in   1                  asynchronous, active-high
//  io_rd       in   1                  CPU I/O read (Controller IORead)
//  io_wr       in   1                  CPU I/O write (Controller IOWrite)
//  io_addr     in   DATA_W             byte address (ALU_result); I/O space = addr[31:10] all ones
//  io_wdata    in   DATA_W             write data (register read_data_2)
//  io_rdata    out  DATA_W             read data to MemorIOtoReg mux
//  io_stall    out  1                  hold PC / suppress register write while high
//  io_err      out  1                  one-cycle pulse on access to unmapped I/O offset
//  switches    in   SW_W               raw board switches
//  confirm_btn in   1                  raw confirm button, active-high
//  led_out     out  LED_BANKS*LED_W    LED pins
// BEHAVIOUR
//  Address map (offset = io_addr[9:0], word aligned):
//   0x060+4k  LED bank k (k<LED_BANKS), R/W; 0x070 switches, R; 0x074 button status, R, bit0 sticky.
//  Reset: led banks 0, io_rdata 0, io_stall 0, io_err 0, debouncers cleared to 0, sticky 0, FSM IDLE.
//  Inputs: switches and confirm_btn each pass a 2-FF synchroniser then io_debounce; confirm rising
//   edge = debounced 0->1, one-cycle pulse btn_rise.
//  Writes: io_wr with LED offset -> bank k <= io_wdata[LED_W-1:0] at next rising edge; visible on
//   led_out the cycle after. Writes to read-only/unmapped offsets ignored.
//  Reads combinational from registered state: LED offset -> zero-extended bank; status -> {0,sticky};
//   unmapped -> 0. Reading status clears sticky on that edge; btn_rise in same cycle wins (sticky=1).
//  io_err = registered pulse, 1 cycle after io_rd|io_wr to unmapped offset inside I/O space.
//  Switch read FSM (READ_BLOCKING=1): IDLE, WAIT, DONE.
//   IDLE: io_rd & offset 0x070 -> io_stall=1 combinationally same cycle; next WAIT.
//   WAIT: io_stall=1; on btn_rise capture debounced switches into sw_cap, next DONE.
//   DONE: io_stall=0, io_rdata = zero-extended sw_cap; next IDLE unconditionally (no re-trigger).
//   btn_rise in IDLE with no read only sets sticky. io_rd dropped in WAIT -> return IDLE, stall 0.
//  READ_BLOCKING=0: switch read returns debounced switches same cycle, io_stall stays 0, FSM idle.
//  io_rd & io_wr both high: write performed, read data still returned; no stall on write.
//  reset mid-WAIT: FSM IDLE, io_stall 0 immediately (asynchronous).
//  Debounce counter saturates; never wraps; counter width = $clog2(DEBOUNCE_CYC)+1.
// STRUCTURE
//  Shared package/defines (definitions.v): IO_SPACE_HI (22'h3FFFFF), offsets LED_BASE 0x060,
//   SW_OFF 0x070, BTN_OFF 0x074, FSM state encodings.
//  Sub-module io_debounce #(W, DEBOUNCE_CYC): sync + stable-count filter, instantiated for
//   switches (W=SW_W) and button (W=1). LED banks via generate loop.
// TESTING
//  1 Reset with DEBOUNCE_CYC=4: assert reset -> led_out 0, io_stall 0, io_rdata 0 while reset high.
//  2 Write 0x0000A5A5 to 0xFFFFFC64 (LED_BANKS=2) -> led_out = 32'hA5A5_0000 next cycle; read back 0xA5A5.
//  3 Blocking read: switches=0x1234, io_rd @0xFFFFFC70 -> stall same cycle; press btn 6 cycles ->
//    stall drops one cycle after btn_rise, io_rdata=0x00001234 in DONE, then FSM IDLE.
//  4 Bounce: toggle confirm every 2 cycles for 10 cycles (DEBOUNCE_CYC=4) -> no btn_rise, stall held.
//  5 Press btn with no read, read 0xFFFFFC74 twice -> 1 then 0; io_rd @0xFFFFFC7C -> io_err pulse.
//  6 Reset asserted in WAIT -> io_stall 0 without clock edge; no switch capture after release.

Source files
------------

// File: rtl/mmio_io_hub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_io_hub_pkg
//  Description : Shared address-map constants, read-FSM state encoding and a
//                helper for LED bank offsets used by the MMIO I/O hub.
//  Revision    : 1.0  initial release
// ============================================================================
package mmio_io_hub_pkg;

    // Upper address bits [31:10] that select the I/O window (32-bit bus).
    localparam logic [21:0] IO_SPACE_HI = 22'h3FFFFF;

    // Word-aligned offsets inside the I/O window (io_addr[9:0]).
    localparam logic [9:0]  LED_BASE    = 10'h060;
    localparam logic [9:0]  SW_OFF      = 10'h070;
    localparam logic [9:0]  BTN_OFF     = 10'h074;

    // Blocking switch-read handshake states.
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } rd_state_e;

    // Offset of LED bank k; banks sit on consecutive words from LED_BASE.
    function automatic logic [9:0] led_offset(input int unsigned k);
        return LED_BASE + 10'(4 * k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_io_hub_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_io_hub_if
//  Description : CPU-side I/O bus of the MMIO hub (read/write strobes, address,
//                data, stall and error). The CPU is the master, the hub the slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface mmio_io_hub_if #(
    parameter int DATA_W = 32
);
    logic              io_rd;
    logic              io_wr;
    logic [DATA_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic [DATA_W-1:0] io_rdata;
    logic              io_stall;
    logic              io_err;

    modport master (
        output io_rd, io_wr, io_addr, io_wdata,
        input  io_rdata, io_stall, io_err
    );

    modport slave (
        input  io_rd, io_wr, io_addr, io_wdata,
        output io_rdata, io_stall, io_err
    );
endinterface
`default_nettype wire

// File: rtl/mmio_io_hub_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_io_hub_debounce
//  Description : 2-FF synchroniser followed by a stable-count filter. The
//                output only follows the input after it has held the same
//                value for DEBOUNCE_CYC consecutive cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_io_hub_debounce #(
    parameter int W            = 1,
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] db_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [W-1:0]     sync1_q;
    logic [W-1:0]     sync2_q;
    logic [W-1:0]     samp_q;
    logic [W-1:0]     db_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-stage synchroniser for the asynchronous board inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Any change restarts the count; the counter parks at its last value
    // so a long-stable input never wraps and re-triggers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            samp_q <= '0;
            cnt_q  <= '0;
            db_q   <= '0;
        end else if (sync2_q != samp_q) begin
            samp_q <= sync2_q;
            cnt_q  <= '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_q  <= cnt_q + CNT_W'(1);
        end else begin
            db_q   <= samp_q;
        end
    end

    assign db_o = db_q;

endmodule
`default_nettype wire

// File: rtl/mmio_io_hub.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_io_hub
//  Description : Memory-mapped I/O hub: debounced switches, LED banks, sticky
//                confirm-button status and an optional blocking switch read
//                that stalls the CPU until the confirm button is pressed.
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_io_hub
    import mmio_io_hub_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int SW_W          = 16,
    parameter int LED_W         = 16,
    parameter int LED_BANKS     = 2,
    parameter int DEBOUNCE_CYC  = 20000,
    parameter int READ_BLOCKING = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    mmio_io_hub_if.slave               bus,
    input  logic [SW_W-1:0]            switches,
    input  logic                       confirm_btn,
    output logic [LED_BANKS*LED_W-1:0] led_out
);

    localparam int HI_W = DATA_W - 10;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [9:0]           w_offset;
    logic                 w_in_space;
    logic                 w_sw_hit;
    logic                 w_btn_hit;
    logic [LED_BANKS-1:0] w_led_hit;
    logic                 w_mapped;

    assign w_offset   = bus.io_addr[9:0];
    assign w_in_space = (bus.io_addr[DATA_W-1:10] == HI_W'(IO_SPACE_HI));
    assign w_sw_hit   = w_in_space && (w_offset == SW_OFF);
    assign w_btn_hit  = w_in_space && (w_offset == BTN_OFF);
    assign w_mapped   = w_sw_hit || w_btn_hit || (|w_led_hit);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [SW_W-1:0] w_sw_db;
    logic            w_btn_db;
    logic            btn_prev_q;
    logic            w_btn_rise;

    mmio_io_hub_debounce #(
        .W            (SW_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_sw_debounce (
        .clock (clock),
        .reset (reset),
        .raw_i (switches),
        .db_o  (w_sw_db)
    );

    mmio_io_hub_debounce #(
        .W            (1),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clock (clock),
        .reset (reset),
        .raw_i (confirm_btn),
        .db_o  (w_btn_db)
    );

    assign w_btn_rise = w_btn_db & ~btn_prev_q;

    // ------------------------------------------------------------------
    // LED banks: one register per bank, concatenated onto led_out
    // ------------------------------------------------------------------
    for (genvar k = 0; k < LED_BANKS; k++) begin : g_led_bank
        logic [LED_W-1:0] bank_q;

        assign w_led_hit[k] = w_in_space && (w_offset == led_offset(k));

        // Bank k captures the low LED_W bits of a write to its offset.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                bank_q <= '0;
            end else if (bus.io_wr && w_led_hit[k]) begin
                bank_q <= bus.io_wdata[LED_W-1:0];
            end
        end

        assign led_out[k*LED_W +: LED_W] = bank_q;
    end

    // Only the low LED_W bits of write data are ever stored.
    if (LED_W < DATA_W) begin : g_wdata_pad
        logic w_unused_wdata;
        assign w_unused_wdata = ^bus.io_wdata[DATA_W-1:LED_W];
    end

    // ------------------------------------------------------------------
    // Switch read handshake FSM
    // ------------------------------------------------------------------
    rd_state_e       state_q;
    rd_state_e       state_d;
    logic            w_stall;
    logic            w_capture;
    logic [SW_W-1:0] sw_cap_q;

    // State register; async reset drops a pending stall immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and stall/capture decode.
    always_comb begin
        state_d   = state_q;
        w_stall   = 1'b0;
        w_capture = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if ((READ_BLOCKING != 0) && bus.io_rd && w_sw_hit) begin
                    w_stall = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!(bus.io_rd && w_sw_hit)) begin
                    state_d = RD_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (w_btn_rise) begin
                        w_capture = 1'b1;
                        state_d   = RD_DONE;
                    end
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky status, switch capture, error pulse, button edge history
    // ------------------------------------------------------------------
    logic sticky_q;
    logic sticky_d;
    logic err_q;

    // A status read clears the flag, but a rise in the same cycle wins.
    // A rise consumed by a pending blocking read does not mark the flag.
    always_comb begin
        sticky_d = sticky_q;
        if (bus.io_rd && w_btn_hit) begin
            sticky_d = 1'b0;
        end
        if (w_btn_rise && !w_capture) begin
            sticky_d = 1'b1;
        end
    end

    // Status/capture registers and the one-cycle unmapped-access pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sticky_q   <= 1'b0;
            sw_cap_q   <= '0;
            err_q      <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            sticky_q   <= sticky_d;
            btn_prev_q <= w_btn_db;
            err_q      <= (bus.io_rd || bus.io_wr) && w_in_space && !w_mapped;
            if (w_capture) begin
                sw_cap_q <= w_sw_db;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data mux (combinational from registered state)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rdata;

    // Zero-extended read of whichever register the offset selects.
    always_comb begin
        w_rdata = '0;
        if (bus.io_rd && !reset) begin
            for (int k = 0; k < LED_BANKS; k++) begin
                if (w_led_hit[k]) begin
                    w_rdata[LED_W-1:0] = led_out[k*LED_W +: LED_W];
                end
            end
            if (w_btn_hit) begin
                w_rdata[0] = sticky_q;
            end
            if (w_sw_hit) begin
                if (READ_BLOCKING != 0) begin
                    if (state_q == RD_DONE) begin
                        w_rdata[SW_W-1:0] = sw_cap_q;
                    end
                end else begin
                    w_rdata[SW_W-1:0] = w_sw_db;
                end
            end
        end
    end

    assign bus.io_rdata = w_rdata;
    assign bus.io_stall = w_stall & ~reset;
    assign bus.io_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_hub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_io_hub
//  Description : Self-checking bench for mmio_io_hub: a vector table for the
//                single-cycle register accesses plus directed sequences for
//                the blocking read, bounce rejection, sticky status and
//                reset-in-wait behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mmio_io_hub;

    logic        clock;
    logic        reset;
    logic [15:0] switches;
    logic        confirm_btn;
    logic [31:0] led_out;

    int checks   = 0;
    int failures = 0;

    mmio_io_hub_if #(.DATA_W(32)) bus ();

    mmio_io_hub #(
        .DATA_W        (32),
        .SW_W          (16),
        .LED_W         (16),
        .LED_BANKS     (2),
        .DEBOUNCE_CYC  (4),
        .READ_BLOCKING (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .switches    (switches),
        .confirm_btn (confirm_btn),
        .led_out     (led_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.io_rd    = rd;
        bus.io_wr    = wr;
        bus.io_addr  = addr;
        bus.io_wdata = wdata;
    endtask

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_led;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit dropped;
        bit held;
        int waited;

        vecs[0]  = '{"wr_bank1",      1'b0, 1'b1, 32'hFFFFFC64, 32'h0000A5A5, 32'h0,      32'hA5A5_0000, 1'b0};
        vecs[1]  = '{"rd_bank1",      1'b1, 1'b0, 32'hFFFFFC64, 32'h0,        32'hA5A5,   32'hA5A5_0000, 1'b0};
        vecs[2]  = '{"wr_bank0_trunc",1'b0, 1'b1, 32'hFFFFFC60, 32'hFFFF1357, 32'h0,      32'hA5A5_1357, 1'b0};
        vecs[3]  = '{"rdwr_bank0",    1'b1, 1'b1, 32'hFFFFFC60, 32'h00002468, 32'h1357,   32'hA5A5_2468, 1'b0};
        vecs[4]  = '{"rd_bank0",      1'b1, 1'b0, 32'hFFFFFC60, 32'h0,        32'h2468,   32'hA5A5_2468, 1'b0};
        vecs[5]  = '{"wr_sw_ro",      1'b0, 1'b1, 32'hFFFFFC70, 32'h0000FFFF, 32'h0,      32'hA5A5_2468, 1'b0};
        vecs[6]  = '{"rd_unmapped",   1'b1, 1'b0, 32'hFFFFFC7C, 32'h0,        32'h0,      32'hA5A5_2468, 1'b1};
        vecs[7]  = '{"wr_bank2_none", 1'b0, 1'b1, 32'hFFFFFC68, 32'h00001111, 32'h0,      32'hA5A5_2468, 1'b1};
        vecs[8]  = '{"rd_outside_io", 1'b1, 1'b0, 32'h00000064, 32'h0,        32'h0,      32'hA5A5_2468, 1'b0};
        vecs[9]  = '{"idle",          1'b0, 1'b0, 32'h0,        32'h0,        32'h0,      32'hA5A5_2468, 1'b0};
        vecs[10] = '{"rd_status0",    1'b1, 1'b0, 32'hFFFFFC74, 32'h0,        32'h0,      32'hA5A5_2468, 1'b0};
        vecs[11] = '{"rd_misaligned", 1'b1, 1'b0, 32'hFFFFFC62, 32'h0,        32'h0,      32'hA5A5_2468, 1'b1};

        // ---------------- reset state ----------------
        reset       = 1'b1;
        switches    = 16'h1234;
        confirm_btn = 1'b0;
        drive(1'b1, 1'b0, 32'hFFFFFC70, 32'h0);
        step();
        @(negedge clock);
        chk("reset_led",   led_out,      32'h0);
        chk("reset_stall", bus.io_stall, 1'b0);
        chk("reset_rdata", bus.io_rdata, 32'h0);
        chk("reset_err",   bus.io_err,   1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;

        // ---------------- table-driven accesses ----------------
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            @(negedge clock);
            chk({vecs[i].name, "_rdata"}, bus.io_rdata, vecs[i].exp_rdata);
            chk({vecs[i].name, "_stall"}, bus.io_stall, 1'b0);
            step();
            chk({vecs[i].name, "_led"},   led_out,      vecs[i].exp_led);
            chk({vecs[i].name, "_err"},   bus.io_err,   vecs[i].exp_err);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // ---------------- blocking switch read ----------------
        drive(1'b1, 1'b0, 32'hFFFFFC70, 32'h0);
        @(negedge clock);
        chk("blk_stall_same_cycle", bus.io_stall, 1'b1);
        chk("blk_rdata_idle",       bus.io_rdata, 32'h0);
        step();
        confirm_btn = 1'b1;
        dropped = 1'b0;
        waited  = 0;
        for (int n = 0; n < 40 && !dropped; n++) begin
            @(negedge clock);
            if (!bus.io_stall) dropped = 1'b1;
            else               waited++;
        end
        chk("blk_stall_released", dropped, 1'b1);
        chk("blk_stall_held_debounce", (waited >= 6), 1'b1);
        chk("blk_rdata_done", bus.io_rdata, 32'h0000_1234);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        chk("blk_after_stall", bus.io_stall, 1'b0);
        chk("blk_after_rdata", bus.io_rdata, 32'h0);
        step();
        confirm_btn = 1'b0;
        repeat (12) step();

        // ---------------- bounce rejection ----------------
        drive(1'b1, 1'b0, 32'hFFFFFC70, 32'h0);
        @(negedge clock);
        chk("bounce_retrigger_stall", bus.io_stall, 1'b1);
        chk("bounce_retrigger_rdata", bus.io_rdata, 32'h0);
        step();
        held = 1'b1;
        for (int t = 0; t < 10; t++) begin
            confirm_btn = ((t / 2) % 2 == 0);
            @(negedge clock);
            held &= bus.io_stall;
            step();
        end
        confirm_btn = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clock);
            held &= bus.io_stall;
            step();
        end
        chk("bounce_stall_held", held, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        chk("bounce_abandon_stall", bus.io_stall, 1'b0);
        step();

        // ---------------- sticky status and error pulse ----------------
        drive(1'b1, 1'b0, 32'hFFFFFC74, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        confirm_btn = 1'b1;
        repeat (10) step();
        confirm_btn = 1'b0;
        repeat (12) step();
        drive(1'b1, 1'b0, 32'hFFFFFC74, 32'h0);
        @(negedge clock);
        chk("status_first",  bus.io_rdata, 32'h1);
        step();
        @(negedge clock);
        chk("status_second", bus.io_rdata, 32'h0);
        step();
        drive(1'b1, 1'b0, 32'hFFFFFC7C, 32'h0);
        @(negedge clock);
        chk("err_not_yet", bus.io_err, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("err_pulse",   bus.io_err, 1'b1);
        step();
        chk("err_one_cycle", bus.io_err, 1'b0);

        // ---------------- reset while waiting ----------------
        drive(1'b1, 1'b0, 32'hFFFFFC70, 32'h0);
        step();
        @(negedge clock);
        chk("rst_wait_stall_before", bus.io_stall, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_wait_stall_async", bus.io_stall, 1'b0);
        chk("rst_wait_rdata",       bus.io_rdata, 32'h0);
        switches    = 16'h5678;
        confirm_btn = 1'b1;
        step();
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        repeat (12) step();
        chk("rst_led_cleared", led_out, 32'h0);
        drive(1'b1, 1'b0, 32'hFFFFFC70, 32'h0);
        @(negedge clock);
        chk("rst_no_capture_stall", bus.io_stall, 1'b1);
        chk("rst_no_capture_rdata", bus.io_rdata, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        chk("rst_abandon_stall", bus.io_stall, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'hFFFFFC74, 32'h0);
        @(negedge clock);
        chk("rst_idle_rise_sticky", bus.io_rdata, 32'h1);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        confirm_btn = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
